// File: rtl/booth_seq_mult_32_if.sv
// ----------------------------------------------------------------------------
// booth_seq_mult_32_if
// Start/done handshake and operand/result bus of the sequential Booth
// multiplier.
//
//   start         1        request, sampled by the multiplier only when idle
//   multiplicand  WIDTH    signed operand M
//   multiplier    WIDTH    signed operand Q
//   busy          1        multiplier is not idle
//   done          1        one-cycle pulse, product valid
//   product       2*WIDTH  signed result, held until the next done
//
// master: the requester (drives start and operands)
// slave : the multiplier
// ----------------------------------------------------------------------------
interface booth_seq_mult_32_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_mult_32.sv
// ----------------------------------------------------------------------------
// CRAdder_64
// 64-bit ripple-carry adder, the only arithmetic element of the Booth
// accumulate path.
//
//   a_i         in  64  addend
//   b_i         in  64  addend
//   cin_i       in  1   carry in
//   sum_o       out 64  a_i + b_i + cin_i (mod 2^64)
//   cout_o      out 1   carry out of bit 63
//   overflow_o  out 1   signed overflow (carry into bit 63 != carry out)
// ----------------------------------------------------------------------------
module CRAdder_64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o,
    output logic        overflow_o
);
    always_comb begin
        logic [64:0] carry;
        // NOTE: every output of a combinational block is given a value on
        // every path (here before the loop) so no latch is inferred.
        carry      = '0;
        sum_o      = '0;
        carry[0]   = cin_i;
        for (int i = 0; i < 64; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o     = carry[64];
        overflow_o = carry[63] ^ carry[64];
    end
endmodule

// ----------------------------------------------------------------------------
// booth_seq_mult_32
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH,
// one Booth step per clock, fixed latency of WIDTH+1 cycles from the
// accepted start to the done pulse.
//
//   clk   in  1   clock, all state on the rising edge
//   rst   in  1   synchronous, active-high reset
//   bus   slave   start/multiplicand/multiplier in, busy/done/product out
// ----------------------------------------------------------------------------
module booth_seq_mult_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_seq_mult_32_if.slave   bus
);
    localparam int PW = 2 * WIDTH;

    if (WIDTH != 32) begin : g_width_check
        $error("booth_seq_mult_32: only WIDTH = 32 is supported");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [PW-1:0]    mc_q,      mc_d;
    logic [WIDTH-1:0] qr_q,      qr_d;
    logic             qm1_q,     qm1_d;
    logic [5:0]       cnt_q,     cnt_d;
    logic [PW-1:0]    product_q, product_d;

    logic [PW-1:0]    add_b;
    logic             add_cin;
    logic [PW-1:0]    add_sum;
    logic             add_cout;
    logic             add_ovf;

    // Booth recoding of {QR[0], qm1}: 01 adds M, 10 subtracts M as
    // ACC + ~MC + 1, 00/11 feed zero so ACC passes through the adder.
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case ({qr_q[0], qm1_q})
            2'b01: add_b = mc_q;
            2'b10: begin
                add_b   = ~mc_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    CRAdder_64 u_adder (
        .a_i        (acc_q),
        .b_i        (add_b),
        .cin_i      (add_cin),
        .sum_o      (add_sum),
        .cout_o     (add_cout),
        .overflow_o (add_ovf)
    );

    // Carry-out is meaningless in modulo-2^64 arithmetic and overflow can
    // never occur for in-range partial products; both are observation only.
    logic unused_adder_flags;
    assign unused_adder_flags = add_cout ^ add_ovf;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        qr_d      = qr_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    mc_d    = {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                    qr_d    = bus.multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = add_sum;
                mc_d  = mc_q << 1;
                qm1_d = qr_q[0];
                qr_d  = {qr_q[WIDTH-1], qr_q[WIDTH-1:1]};
                cnt_d = cnt_q + 6'd1;
                // The final step's adder result is the product; capture it
                // directly so ACC need not be read one cycle later.
                if (cnt_q == LAST_STEP) begin
                    product_d = add_sum;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their _d values from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            qr_q      <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            qr_q      <= qr_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_seq_mult_32.sv
// ----------------------------------------------------------------------------
// tb_booth_seq_mult_32
// Self-checking bench for booth_seq_mult_32: table of signed corner products,
// hand sequences for latency, ignored start and mid-run reset, and a
// back-to-back random run with start held high. Expected products are queued
// when an operation is accepted and compared when done pulses.
// ----------------------------------------------------------------------------
module tb_booth_seq_mult_32;
    localparam int W       = 32;
    localparam int N_RAND  = 1500;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_seq_mult_32_if #(.WIDTH(W)) bus ();

    booth_seq_mult_32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    int          done_count = 0;
    longint      cycle = 0;
    longint      last_done_cycle = -1;
    bit          b2b_mode = 1'b0;
    logic        rst_at_edge;
    logic [63:0] prev_product = '0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)",
                      name, actual, expected, cycle);
    endtask

    always @(posedge clk) begin
        cycle       <= cycle + 1;
        rst_at_edge <= rst;
    end

    // Monitor: scoreboard compare on done, product stability, overflow.
    always @(negedge clk) begin
        if (bus.busy && !bus.done) begin
            assert (dut.u_adder.overflow_o === 1'b0)
            else check("adder_overflow_in_run", {63'd0, dut.u_adder.overflow_o}, 64'd0);
        end
        if (bus.product !== prev_product)
            check("product_changes_only_on_done_or_reset",
                  {63'd0, (bus.done === 1'b1) || (rst_at_edge === 1'b1)}, 64'd1);
        prev_product = bus.product;
        if (bus.done === 1'b1) begin
            done_count++;
            check("scoreboard_has_entry_at_done", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) check("product", bus.product, exp_q.pop_front());
            if (b2b_mode && last_done_cycle >= 0)
                check("back_to_back_interval", 64'(cycle - last_done_cycle), 64'd34);
            last_done_cycle = cycle;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Must be called while the DUT is idle; returns in cycle k+1.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus.start        = 1'b0;
    endtask

    // Waits for done starting from cycle k+first; checks latency 33, then
    // steps into the following idle cycle.
    task automatic finish_op(input string name, input int first);
        int cyc = first;
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'd33);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int accepted;
        int guard;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[6] = '{32'hFFFF_FFFE, 32'h4000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{32'hFFFF_0000, 32'h0001_0000, 64'hFFFF_FFFF_0000_0000};

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) tick();
        check("reset_busy",    {63'd0, bus.busy}, 64'd0);
        check("reset_done",    {63'd0, bus.done}, 64'd0);
        check("reset_product", bus.product, 64'd0);
        rst = 1'b0;
        tick();

        // 3 * -5: cycle-exact busy/done profile.
        start_op(32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        for (int c = 1; c <= 33; c++) begin
            check($sformatf("lat_busy_done_k+%0d", c), {62'd0, bus.busy, bus.done},
                  {62'd0, 1'b1, (c == 33)});
            tick();
        end
        check("idle_after_done_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].exp);
            finish_op($sformatf("vec%0d", i), 1);
        end

        // 7 * 9 with a 2 * 2 start pulse at cycle k+10: ignored.
        d0 = done_count;
        start_op(32'd7, 32'd9, 64'd63);
        repeat (9) tick();
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd2;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        finish_op("ignored_start", 11);
        repeat (40) tick();
        check("ignored_start_single_done", 64'(done_count - d0), 64'd1);

        // Reset in cycle k+12 of a run discards it.
        d0 = done_count;
        start_op(32'd5, 32'd5, 64'd25);
        repeat (11) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrun_reset_busy",    {63'd0, bus.busy}, 64'd0);
        check("midrun_reset_done",    {63'd0, bus.done}, 64'd0);
        check("midrun_reset_product", bus.product, 64'd0);
        start_op(32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6);
        finish_op("after_reset", 1);
        check("after_reset_done_count", 64'(done_count - d0), 64'd1);

        // Random back-to-back with start held high; operands scrambled while busy.
        b2b_mode        = 1'b1;
        last_done_cycle = -1;
        accepted        = 0;
        guard           = 0;
        bus.start       = 1'b1;
        while (accepted < N_RAND && guard < N_RAND * 40) begin
            if (!bus.busy) begin
                case ($urandom_range(0, 7))
                    0:       ra = 32'h8000_0000;
                    1:       ra = 32'h0000_0000;
                    2:       ra = 32'hFFFF_FFFF;
                    default: ra = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0:       rb = 32'h8000_0000;
                    1:       rb = 32'h7FFF_FFFF;
                    default: rb = $urandom;
                endcase
                bus.multiplicand = ra;
                bus.multiplier   = rb;
                exp_q.push_back(64'(longint'($signed(ra)) * longint'($signed(rb))));
                accepted++;
            end else begin
                bus.multiplicand = $urandom;
                bus.multiplier   = $urandom;
            end
            tick();
            guard++;
        end
        bus.start = 1'b0;
        check("random_ops_accepted", 64'(accepted), 64'(N_RAND));
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        b2b_mode = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
